// File: rtl/kt_pkg.sv
// Shared definitions for the knight's tour move sequencer: command fields,
// heading and response constants, and the sequencer state type.
package kt_pkg;

  localparam logic [3:0] MOVE         = 4'h2;
  localparam logic [3:0] MOVE_FANFARE = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] POS_ACK  = 8'hA5;
  localparam logic [7:0] MOVE_ACK = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } seq_state_t;

  // cmd_proc command word layout
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] heading;
    logic [3:0] squares;
  } move_cmd_t;

endpackage

// File: rtl/tour_move_sequencer_if.sv
// Command path between the sequencer and cmd_proc.
interface tour_move_sequencer_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport master (
    output cmd,
    output cmd_rdy,
    input  clr_cmd_rdy,
    input  send_resp
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    output clr_cmd_rdy,
    output send_resp
  );
endinterface

// File: rtl/knight_move_decode.sv
// Decodes a one-hot knight move into its vertical and horizontal component
// commands. Illegal codes (zero-hot or multi-hot) resolve to the lowest set
// bit, with zero-hot treated as bit0.
module knight_move_decode
  import kt_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic [2:0] sel;
  logic       dx_pos;
  logic       dx_two;
  logic       dy_pos;
  logic       dy_two;
  move_cmd_t  vert;
  move_cmd_t  horz;

  // Lowest set bit wins; scanning from the top lets lower bits overwrite.
  always_comb begin
    sel = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (move[7 - i]) sel = 3'(7 - i);
    end
  end

  // Displacement sign and magnitude for each of the eight L-moves.
  always_comb begin
    dx_pos = 1'b1;
    dx_two = 1'b0;
    dy_pos = 1'b1;
    dy_two = 1'b1;
    case (sel)
      3'd0: begin dx_pos = 1'b1; dx_two = 1'b0; dy_pos = 1'b1; dy_two = 1'b1; end
      3'd1: begin dx_pos = 1'b0; dx_two = 1'b0; dy_pos = 1'b1; dy_two = 1'b1; end
      3'd2: begin dx_pos = 1'b0; dx_two = 1'b1; dy_pos = 1'b1; dy_two = 1'b0; end
      3'd3: begin dx_pos = 1'b0; dx_two = 1'b1; dy_pos = 1'b0; dy_two = 1'b0; end
      3'd4: begin dx_pos = 1'b0; dx_two = 1'b0; dy_pos = 1'b0; dy_two = 1'b1; end
      3'd5: begin dx_pos = 1'b1; dx_two = 1'b0; dy_pos = 1'b0; dy_two = 1'b1; end
      3'd6: begin dx_pos = 1'b1; dx_two = 1'b1; dy_pos = 1'b0; dy_two = 1'b0; end
      3'd7: begin dx_pos = 1'b1; dx_two = 1'b1; dy_pos = 1'b1; dy_two = 1'b0; end
      default: ;
    endcase
  end

  // Assemble the two component commands.
  always_comb begin
    vert.opcode  = MOVE;
    vert.heading = dy_pos ? HDG_N : HDG_S;
    vert.squares = dy_two ? 4'd2 : 4'd1;
    horz.opcode  = MOVE_FANFARE;
    horz.heading = dx_pos ? HDG_E : HDG_W;
    horz.squares = dx_two ? 4'd2 : 4'd1;
    vert_cmd     = vert;
    horz_cmd     = horz;
  end

endmodule

// File: rtl/tour_move_sequencer.sv
// Walks a solved knight's tour, issuing each move to cmd_proc as a vertical
// then a horizontal component command, and muxes the command path between
// the UART and the sequencer.
module tour_move_sequencer
  import kt_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_tour,
  input  logic [7:0]            move,
  output logic [4:0]            mv_indx,
  input  logic [15:0]           cmd_UART,
  input  logic                  cmd_rdy_UART,
  tour_move_sequencer_if.master cmd_bus,
  output logic [7:0]            resp,
  output logic                  tour_active
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic [4:0]  mv_indx_nxt;
  logic        tour_active_nxt;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic [15:0] seq_cmd;
  logic        seq_rdy;

  knight_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  // State, move index and ownership flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mv_indx     <= '0;
      tour_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      mv_indx     <= mv_indx_nxt;
      tour_active <= tour_active_nxt;
    end
  end

  // Next-state logic; clr_cmd_rdy is the only exit from VERT/HORZ, so a
  // send_resp arriving there (alone or with clr) is dropped.
  always_comb begin
    state_nxt       = state;
    mv_indx_nxt     = mv_indx;
    tour_active_nxt = tour_active;
    case (state)
      IDLE: begin
        if (start_tour) begin
          state_nxt       = VERT;
          mv_indx_nxt     = '0;
          tour_active_nxt = 1'b1;
        end
      end
      VERT: begin
        if (cmd_bus.clr_cmd_rdy) state_nxt = WAIT_V;
      end
      WAIT_V: begin
        if (cmd_bus.send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        if (cmd_bus.clr_cmd_rdy) state_nxt = WAIT_H;
      end
      WAIT_H: begin
        if (cmd_bus.send_resp) begin
          if (mv_indx == LAST_INDX) begin
            state_nxt       = IDLE;
            tour_active_nxt = 1'b0;
          end else begin
            state_nxt   = VERT;
            mv_indx_nxt = mv_indx + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer-side command and valid, decoded from the current state.
  always_comb begin
    seq_rdy = 1'b0;
    seq_cmd = vert_cmd;
    case (state)
      VERT:    seq_rdy = 1'b1;
      HORZ:    begin seq_rdy = 1'b1; seq_cmd = horz_cmd; end
      WAIT_H:  seq_cmd = horz_cmd;
      default: ;
    endcase
  end

  // Command path mux: UART owns it unless a tour is in progress.
  always_comb begin
    cmd_bus.cmd     = cmd_UART;
    cmd_bus.cmd_rdy = cmd_rdy_UART;
    if (tour_active) begin
      cmd_bus.cmd     = seq_cmd;
      cmd_bus.cmd_rdy = seq_rdy;
    end
  end

  // Response byte: the final horizontal completion reports A5 like UART traffic.
  always_comb begin
    resp = POS_ACK;
    if (tour_active && !(state == WAIT_H && mv_indx == LAST_INDX)) resp = MOVE_ACK;
  end

endmodule

// File: doc/tour_move_sequencer.md
Name: tour_move_sequencer

Overview:
- Sequences a solved Knight's Tour into cmd_proc-format move commands once the solver asserts start_tour.
- Splits each L-move into a vertical component command followed by a horizontal component command.
- Waits for cmd_proc completion (send_resp) after each component, then advances the move index.
- Sits between UART_wrapper, tour_logic and cmd_proc. Muxes the command and ready path, and generates the response byte sent back over UART.

Parameters:
- NUM_MOVES, 24, number of moves in the tour (5x5 board). Index range 0..NUM_MOVES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_tour  in  1  one-cycle pulse from the solver; begins the tour at index 0
- move  in  8  one-hot move for mv_indx, read combinationally from the solver's move store
- mv_indx  out  5  index of the move being executed
- cmd_UART  in  16  command from UART_wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy  in  1  cmd_proc has consumed the current command
- send_resp  in  1  one-cycle pulse from cmd_proc when a command completes
- cmd  out  16  command presented to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- resp  out  8  response byte to UART_wrapper
- tour_active  out  1  high while the sequencer owns the command path

Behaviour:
- Reset values: state=IDLE, mv_indx=0, tour_active=0.
- Command mux:
  - tour_active=0: cmd=cmd_UART and cmd_rdy=cmd_rdy_UART.
  - tour_active=1: cmd and cmd_rdy are driven internally; cmd_rdy_UART is ignored.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcode 4'h2 = move; opcode 4'h3 = move with fanfare.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (bit: dx,dy):
  - bit0: +1,+2
  - bit1: -1,+2
  - bit2: -2,+1
  - bit3: -2,-1
  - bit4: -1,-2
  - bit5: +1,-2
  - bit6: +2,-1
  - bit7: +2,+1
- Command per component:
  - Vertical: opcode 4'h2, heading N if dy>0 else S, squares |dy|.
  - Horizontal: opcode 4'h3, heading E if dx>0 else W, squares |dx|.
  - A zero-hot or multi-hot move is illegal. It must decode deterministically to bit0 priority (lowest set bit); zero-hot decodes as bit0.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- Transitions:
  - IDLE: start_tour -> VERT; mv_indx<=0; tour_active<=1.
  - VERT: cmd_rdy=1 with the vertical command; clr_cmd_rdy -> WAIT_V.
  - WAIT_V: cmd_rdy=0; send_resp -> HORZ.
  - HORZ: cmd_rdy=1 with the horizontal command; clr_cmd_rdy -> WAIT_H.
  - WAIT_H: cmd_rdy=0; send_resp:
    - if mv_indx==NUM_MOVES-1 -> IDLE, tour_active<=0;
    - else mv_indx<=mv_indx+1 -> VERT.
- Handshake rules:
  - cmd_rdy rises the cycle after entry into VERT/HORZ and holds until clr_cmd_rdy is sampled.
  - Command contents are stable for the whole time cmd_rdy is high.
- Response byte (combinational):
  - tour_active=0: 8'hA5.
  - tour_active=1: 8'h5A, except 8'hA5 in WAIT_H when mv_indx==NUM_MOVES-1.
  - Result: the final horizontal completion returns A5; all earlier component completions return 5A.
- Boundary conditions:
  - start_tour outside IDLE is ignored.
  - send_resp in VERT/HORZ (before clr_cmd_rdy) is ignored.
  - clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: take clr only.
  - rst mid-tour returns to IDLE the next cycle, with mv_indx=0, cmd_rdy=0 and the mux back on UART.
  - No wrap: mv_indx never exceeds NUM_MOVES-1.

Decomposition:
- Shared package kt_pkg holds:
  - opcode constants MOVE=4'h2, MOVE_FANFARE=4'h3;
  - heading constants HDG_N/W/S/E;
  - response constants POS_ACK=8'hA5, MOVE_ACK=8'h5A;
  - state enum seq_state_t.
- One natural sub-module: knight_move_decode, a combinational one-hot move -> {vert_cmd, horz_cmd} decoder.

Test Plan:
- Idle pass-through: cmd_UART=16'h2003, cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1, resp=8'hA5, tour_active=0.
- Single move bit2 after start_tour:
  - First command: cmd=16'h2001 (N,1), held until clr_cmd_rdy.
  - After send_resp, resp=5A and the next command is cmd=16'h33F2 (W,2, fanfare).
- Full tour with NUM_MOVES=3, moves bit2, bit0, bit7, with clr/send_resp modelled with random 1-20 cycle delays:
  - Commands in order: 2001, 33F2, 2002, 3BF1, 2001, 3BF2.
  - Response after the last horizontal component is A5; all earlier responses are 5A.
  - Returns to IDLE afterwards.
- Ordering: send_resp pulsed in VERT before clr_cmd_rdy -> state unchanged, cmd_rdy still 1.
- Reset mid-tour: rst in WAIT_H at mv_indx=1 -> next cycle IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART.
- Restart ignored: start_tour during WAIT_V -> no change to mv_indx or state.
